// File: rtl/snn_layer_sequencer_pkg.sv
// Shared types and default layer sizes for the SNN layer sequencer.
package snn_layer_sequencer_pkg;

    localparam int unsigned DEF_NUM_NEURONS        = 10;
    localparam int unsigned DEF_PREV_LAYER_NEURONS = 784;
    localparam int unsigned DEF_WEIGHT_WIDTH       = 32;
    localparam int unsigned DEF_ADDR_WIDTH         = 10;
    localparam int unsigned DEF_NUM_STEPS          = 350;
    localparam int unsigned DEF_CNT_WIDTH          = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_FETCH,
        ST_STEP,
        ST_SAMPLE,
        ST_DECIDE,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/snn_layer_sequencer_spike_argmax.sv
// Saturating per-neuron spike counters and a one-neuron-per-cycle argmax scan.
module snn_layer_sequencer_spike_argmax
    import snn_layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           count_en,
    input  logic [NUM_NEURONS-1:0]         spikes,
    input  logic                           start_scan,
    output logic [$clog2(NUM_NEURONS)-1:0] idx,
    output logic                           idx_valid
);
    localparam int unsigned IDX_W = $clog2(NUM_NEURONS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q [NUM_NEURONS];
    logic                 scan_q;
    logic                 valid_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     best_idx_q;
    logic [CNT_WIDTH-1:0] best_cnt_q;
    logic                 last_c;

    assign last_c = (ptr_q == IDX_W'(NUM_NEURONS - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= '0;
        end else if (count_en) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                if (spikes[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    // Strict '>' against a zero seed: lowest index wins ties, all-zero gives 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            scan_q     <= 1'b0;
            valid_q    <= 1'b0;
            ptr_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
        end else begin
            valid_q <= scan_q && last_c;
            if (start_scan) begin
                scan_q     <= 1'b1;
                ptr_q      <= '0;
                best_idx_q <= '0;
                best_cnt_q <= '0;
            end else if (scan_q) begin
                if (cnt_q[ptr_q] > best_cnt_q) begin
                    best_cnt_q <= cnt_q[ptr_q];
                    best_idx_q <= ptr_q;
                end
                ptr_q <= ptr_q + IDX_W'(1);
                if (last_c) scan_q <= 1'b0;
            end
        end
    end

    assign idx       = best_idx_q;
    assign idx_valid = valid_q;

endmodule

// File: rtl/snn_layer_sequencer.sv
// SNN layer controller: streams weights, runs NUM_STEPS timesteps, reports argmax class.
// Optional SNN_SEQ_ABORT_EN adds an 'abort' input that returns any active operation to IDLE.
module snn_layer_sequencer
    import snn_layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_NEURONS        = DEF_NUM_NEURONS,
    parameter int unsigned PREV_LAYER_NEURONS = DEF_PREV_LAYER_NEURONS,
    parameter int unsigned WEIGHT_WIDTH       = DEF_WEIGHT_WIDTH,
    parameter int unsigned ADDR_WIDTH         = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_STEPS          = DEF_NUM_STEPS,
    parameter int unsigned CNT_WIDTH          = DEF_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef SNN_SEQ_ABORT_EN
    input  logic                           abort,
`endif
    input  logic                           load_weights,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [WEIGHT_WIDTH-1:0]        cfg_data,
    input  logic                           start,
    input  logic                           frame_valid,
    output logic                           frame_ready,
    input  logic [PREV_LAYER_NEURONS-1:0]  frame_data,
    output logic [NUM_NEURONS-1:0]         n_wen,
    output logic [ADDR_WIDTH-1:0]          n_waddr,
    output logic [WEIGHT_WIDTH-1:0]        n_wdata,
    output logic                           n_rstn,
    output logic                           n_en,
    output logic [PREV_LAYER_NEURONS-1:0]  n_spike_in,
    input  logic [NUM_NEURONS-1:0]         n_spike_out,
    output logic                           busy,
    output logic                           weights_loaded,
    output logic                           class_valid,
    output logic [$clog2(NUM_NEURONS)-1:0] class_idx
);
    localparam int unsigned IDX_W  = $clog2(NUM_NEURONS);
    localparam int unsigned STEP_W = $clog2(NUM_STEPS + 1);

    seq_state_e                    state_q, state_d;
    logic [IDX_W-1:0]              sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic                          load_done_q, load_done_d;
    logic [STEP_W-1:0]             step_q, step_d;
    logic                          wl_q, wl_d;
    logic                          cfg_ready_q, cfg_ready_d;
    logic                          frame_ready_q, frame_ready_d;
    logic [NUM_NEURONS-1:0]        n_wen_q, n_wen_d;
    logic [ADDR_WIDTH-1:0]         n_waddr_q, n_waddr_d;
    logic [WEIGHT_WIDTH-1:0]       n_wdata_q, n_wdata_d;
    logic                          n_rstn_q, n_rstn_d;
    logic                          n_en_q, n_en_d;
    logic [PREV_LAYER_NEURONS-1:0] n_spike_in_q, n_spike_in_d;
    logic                          busy_q, busy_d;
    logic                          class_valid_q, class_valid_d;
    logic [IDX_W-1:0]              class_idx_q, class_idx_d;

    logic             abort_c;
    logic             cfg_fire_c;
    logic             frame_fire_c;
    logic             last_step_c;
    logic             scan_valid_c;
    logic [IDX_W-1:0] scan_idx_c;

`ifdef SNN_SEQ_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    assign cfg_fire_c   = (state_q == ST_LOAD) && cfg_valid && cfg_ready_q && !abort_c;
    assign frame_fire_c = (state_q == ST_FETCH) && frame_valid && frame_ready_q && !abort_c;
    assign last_step_c  = (step_q == STEP_W'(NUM_STEPS - 1));

    snn_layer_sequencer_spike_argmax #(
        .NUM_NEURONS (NUM_NEURONS),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .clear      ((state_q == ST_CLEAR) || abort_c),
        .count_en   (state_q == ST_SAMPLE),
        .spikes     (n_spike_out),
        .start_scan ((state_q == ST_SAMPLE) && last_step_c),
        .idx        (scan_idx_c),
        .idx_valid  (scan_valid_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_weights)       state_d = ST_LOAD;
                else if (start && wl_q) state_d = ST_CLEAR;
            end
            ST_LOAD:   if (load_done_q) state_d = ST_IDLE;
            ST_CLEAR:  state_d = ST_FETCH;
            ST_FETCH:  if (frame_valid) state_d = ST_STEP;
            ST_STEP:   state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = last_step_c ? ST_DECIDE : ST_FETCH;
            ST_DECIDE: if (scan_valid_c) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort_c && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    // Datapath and registered outputs, decoded from the upcoming state.
    always_comb begin
        sel_d        = sel_q;
        addr_d       = addr_q;
        load_done_d  = load_done_q;
        step_d       = step_q;
        wl_d         = wl_q;
        n_wen_d      = '0;
        n_waddr_d    = n_waddr_q;
        n_wdata_d    = n_wdata_q;
        n_spike_in_d = n_spike_in_q;
        class_idx_d  = class_idx_q;

        if ((state_q == ST_IDLE) && (state_d == ST_LOAD)) begin
            sel_d       = '0;
            addr_d      = '0;
            load_done_d = 1'b0;
            wl_d        = 1'b0;
        end
        if (cfg_fire_c) begin
            n_wen_d   = NUM_NEURONS'(1) << sel_q;
            n_waddr_d = addr_q;
            n_wdata_d = cfg_data;
            if (addr_q == ADDR_WIDTH'(PREV_LAYER_NEURONS - 1)) begin
                addr_d = '0;
                if (sel_q == IDX_W'(NUM_NEURONS - 1)) load_done_d = 1'b1;
                else                                  sel_d = sel_q + IDX_W'(1);
            end else begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
        if ((state_q == ST_LOAD) && load_done_q) wl_d = 1'b1;
        if (abort_c && (state_q == ST_LOAD))     wl_d = 1'b0;

        if (state_q == ST_CLEAR)  step_d = '0;
        if (state_q == ST_SAMPLE) step_d = step_q + STEP_W'(1);
        if (frame_fire_c)         n_spike_in_d = frame_data;
        if (state_d == ST_DONE)   class_idx_d = scan_idx_c;

        cfg_ready_d   = (state_d == ST_LOAD) && !load_done_d;
        frame_ready_d = (state_d == ST_FETCH);
        n_en_d        = (state_d == ST_STEP);
        n_rstn_d      = (state_d != ST_CLEAR);
        busy_d        = (state_d != ST_IDLE);
        class_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q         <= '0;
            addr_q        <= '0;
            load_done_q   <= 1'b0;
            step_q        <= '0;
            wl_q          <= 1'b0;
            cfg_ready_q   <= 1'b0;
            frame_ready_q <= 1'b0;
            n_wen_q       <= '0;
            n_waddr_q     <= '0;
            n_wdata_q     <= '0;
            n_rstn_q      <= 1'b1;
            n_en_q        <= 1'b0;
            n_spike_in_q  <= '0;
            busy_q        <= 1'b0;
            class_valid_q <= 1'b0;
            class_idx_q   <= '0;
        end else begin
            sel_q         <= sel_d;
            addr_q        <= addr_d;
            load_done_q   <= load_done_d;
            step_q        <= step_d;
            wl_q          <= wl_d;
            cfg_ready_q   <= cfg_ready_d;
            frame_ready_q <= frame_ready_d;
            n_wen_q       <= n_wen_d;
            n_waddr_q     <= n_waddr_d;
            n_wdata_q     <= n_wdata_d;
            n_rstn_q      <= n_rstn_d;
            n_en_q        <= n_en_d;
            n_spike_in_q  <= n_spike_in_d;
            busy_q        <= busy_d;
            class_valid_q <= class_valid_d;
            class_idx_q   <= class_idx_d;
        end
    end

    assign cfg_ready      = cfg_ready_q;
    assign frame_ready    = frame_ready_q;
    assign n_wen          = n_wen_q;
    assign n_waddr        = n_waddr_q;
    assign n_wdata        = n_wdata_q;
    assign n_rstn         = n_rstn_q;
    assign n_en           = n_en_q;
    assign n_spike_in     = n_spike_in_q;
    assign busy           = busy_q;
    assign weights_loaded = wl_q;
    assign class_valid    = class_valid_q;
    assign class_idx      = class_idx_q;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Scoreboard bench for snn_layer_sequencer: 3 neurons x 4 synapses, 5 steps, 2-bit counters.
module tb_snn_layer_sequencer;
    localparam int unsigned N  = 3;
    localparam int unsigned P  = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned WW = 8;
    localparam int unsigned NS = 5;
    localparam int unsigned CW = 2;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [N-1:0]  wen;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst, load_weights, cfg_valid, start, frame_valid;
    logic [WW-1:0] cfg_data;
    logic [P-1:0]  frame_data;
    logic [N-1:0]  n_spike_out;
    logic          cfg_ready, frame_ready, n_rstn, n_en, busy, weights_loaded, class_valid;
    logic [N-1:0]  n_wen;
    logic [AW-1:0] n_waddr;
    logic [WW-1:0] n_wdata;
    logic [P-1:0]  n_spike_in;
    logic [IW-1:0] class_idx;
`ifdef SNN_SEQ_ABORT_EN
    logic          abort;
`endif

    always #5 clk = ~clk;

    snn_layer_sequencer #(
        .NUM_NEURONS(N), .PREV_LAYER_NEURONS(P), .WEIGHT_WIDTH(WW),
        .ADDR_WIDTH(AW), .NUM_STEPS(NS), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef SNN_SEQ_ABORT_EN
        .abort(abort),
`endif
        .load_weights(load_weights), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .start(start), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .frame_data(frame_data), .n_wen(n_wen),
        .n_waddr(n_waddr), .n_wdata(n_wdata), .n_rstn(n_rstn), .n_en(n_en),
        .n_spike_in(n_spike_in), .n_spike_out(n_spike_out), .busy(busy),
        .weights_loaded(weights_loaded), .class_valid(class_valid), .class_idx(class_idx)
    );

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;
    int rstn_cnt = 0;
    int done_cnt = 0;
    bit stall = 1'b0;

    wr_t          wr_q[$];
    logic [P-1:0] fr_q[$];
    int           cls_q[$];
    logic [N-1:0] pat[NS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: saturated spike totals, first maximum wins.
    function automatic int exp_class();
        int c[N];
        int best;
        for (int n = 0; n < N; n++) begin
            c[n] = 0;
            for (int s = 0; s < NS; s++) if (pat[s][n]) c[n]++;
            if (c[n] > (1 << CW) - 1) c[n] = (1 << CW) - 1;
        end
        best = 0;
        for (int n = 1; n < N; n++) if (c[n] > c[best]) best = n;
        return best;
    endfunction

    task automatic set_pat(input logic [N*NS-1:0] v);
        for (int s = 0; s < NS; s++) pat[s] = v[s*N +: N];
    endtask

    task automatic set_rand_pat();
        for (int s = 0; s < NS; s++) pat[s] = N'($urandom);
    endtask

    initial begin : encoder
        frame_valid = 1'b0;
        frame_data  = '0;
        forever begin
            @(negedge clk);
            if (frame_ready && !stall && ($urandom_range(3) != 0)) begin
                frame_valid = 1'b1;
                frame_data  = P'($urandom);
                fr_q.push_back(frame_data);
            end else begin
                frame_valid = 1'b0;
            end
        end
    end

    // Neuron model plus spike-frame monitor.
    initial begin : neurons
        n_spike_out = '0;
        forever begin
            @(negedge clk);
            if (!n_rstn) rstn_cnt++;
            if (n_en) begin
                if (fr_q.size() == 0) chk("frame_unexpected", 32'(n_spike_in), 32'hFFFF);
                else                  chk("frame_data", 32'(n_spike_in), 32'(fr_q.pop_front()));
                n_spike_out = (en_cnt < NS) ? pat[en_cnt] : '0;
                en_cnt++;
            end
        end
    end

    initial begin : wr_monitor
        wr_t w;
        forever begin
            @(negedge clk);
            if (n_wen != '0) begin
                if (wr_q.size() == 0) begin
                    chk("write_unexpected", 32'(n_wen), 32'h0);
                end else begin
                    w = wr_q.pop_front();
                    chk("write_beat", 32'({n_wen, n_waddr, n_wdata}), 32'(w));
                end
            end
        end
    end

    initial begin : cls_monitor
        forever begin
            @(negedge clk);
            if (class_valid) begin
                if (cls_q.size() == 0) chk("class_unexpected", 32'(class_idx), 32'hFF);
                else                   chk("class_idx", 32'(class_idx), 32'(cls_q.pop_front()));
                done_cnt++;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic load_all(input bit with_start);
        int k = 0;
        int guard = 0;
        wr_t w;
        @(negedge clk);
        load_weights = 1'b1;
        start = with_start;
        @(negedge clk);
        load_weights = 1'b0;
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_cfg_ready", 32'(cfg_ready), 32'd1);
        while (k < N * P && guard < 1000) begin
            @(negedge clk);
            guard++;
            cfg_valid = ($urandom_range(3) != 0);
            cfg_data  = WW'($urandom);
            if (cfg_valid && cfg_ready) begin
                w.wen  = N'(1) << (k / P);
                w.addr = AW'(k % P);
                w.data = cfg_data;
                wr_q.push_back(w);
                k++;
            end
        end
        if (k < N * P) chk("load_timeout", 32'(k), 32'(N * P));
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("wl_during_last_write", 32'(weights_loaded), 32'd0);
        chk("cfg_ready_after_last", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        chk("wl_after_load", 32'(weights_loaded), 32'd1);
        chk("busy_after_load", 32'(busy), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int guard = 0;
        while (done_cnt < target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (done_cnt < target) chk("class_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic run_image();
        int d0;
        d0 = done_cnt;
        en_cnt = 0;
        rstn_cnt = 0;
        cls_q.push_back(exp_class());
        pulse_start();
        wait_done(d0 + 1);
        chk("n_en_pulses", 32'(en_cnt), 32'(NS));
        chk("n_rstn_pulses", 32'(rstn_cnt), 32'd1);
        @(negedge clk);
    endtask

    initial begin : main
        int d0;
        int e0;
        int pulses;
        int guard;
        rst = 1'b1;
        load_weights = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        start = 1'b0;
`ifdef SNN_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wl", 32'(weights_loaded), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_frame_ready", 32'(frame_ready), 32'd0);
        chk("rst_n_wen", 32'(n_wen), 32'd0);
        chk("rst_n_en", 32'(n_en), 32'd0);
        chk("rst_class_valid", 32'(class_valid), 32'd0);
        chk("rst_n_rstn", 32'(n_rstn), 32'd1);
        chk("rst_class_idx", 32'(class_idx), 32'd0);
        chk("rst_spike_in", 32'(n_spike_in), 32'd0);
        chk("rst_waddr", 32'(n_waddr), 32'd0);
        rst = 1'b0;

        pulse_start();
        @(negedge clk);
        chk("start_unloaded_busy", 32'(busy), 32'd0);
        chk("start_unloaded_frame_ready", 32'(frame_ready), 32'd0);

        load_all(1'b1);

        set_pat({3'b010, 3'b010, 3'b011, 3'b010, 3'b011}); run_image();
        set_pat({3'b010, 3'b010, 3'b001, 3'b001, 3'b011}); run_image();
        set_pat({3'b010, 3'b010, 3'b011, 3'b011, 3'b011}); run_image();
        set_pat('0);                                        run_image();
        set_pat({3'b000, 3'b000, 3'b100, 3'b000, 3'b000}); run_image();
        for (int i = 0; i < 6; i++) begin
            set_rand_pat();
            run_image();
        end

        // Encoder stall inside FETCH.
        set_rand_pat();
        d0 = done_cnt;
        en_cnt = 0;
        cls_q.push_back(exp_class());
        pulse_start();
        guard = 0;
        while (en_cnt < 2 && guard < 500) begin @(negedge clk); guard++; end
        stall = 1'b1;
        repeat (4) @(negedge clk);
        e0 = en_cnt;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (n_en) pulses++;
        end
        chk("stall_n_en", 32'(pulses), 32'd0);
        chk("stall_steps", 32'(en_cnt), 32'(e0));
        chk("stall_frame_ready", 32'(frame_ready), 32'd1);
        stall = 1'b0;
        wait_done(d0 + 1);
        chk("stall_n_en_pulses", 32'(en_cnt), 32'(NS));
        @(negedge clk);

`ifdef SNN_SEQ_ABORT_EN
        stall = 1'b1;
        set_rand_pat();
        pulse_start();
        guard = 0;
        while (!frame_ready && guard < 50) begin @(negedge clk); guard++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wl", 32'(weights_loaded), 32'd1);
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        chk("abort_no_class", 32'(done_cnt), 32'(d0));
        stall = 1'b0;
        fr_q.delete();
        set_rand_pat();
        run_image();
`endif

        // Synchronous reset while a timestep is enabled.
        set_rand_pat();
        en_cnt = 0;
        pulse_start();
        guard = 0;
        while (!n_en && guard < 200) begin @(negedge clk); guard++; end
        chk("n_en_before_rst", 32'(n_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_wl", 32'(weights_loaded), 32'd0);
        chk("rst_mid_n_en", 32'(n_en), 32'd0);
        d0 = done_cnt;
        repeat (30) @(negedge clk);
        chk("rst_mid_no_class", 32'(done_cnt), 32'(d0));
        fr_q.delete();

        load_all(1'b0);
        set_rand_pat();
        run_image();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
